// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 mouse receiver: frame FSM states,
// byte-0 bit positions and the decoded packet struct.
package ps2_rx_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  typedef struct packed {
    logic [8:0] dx;
    logic [8:0] dy;
    logic [2:0] btn;  // {middle, right, left}
    logic [1:0] ovf;  // {y, x}
  } mouse_pkt_t;

  function automatic mouse_pkt_t build_pkt(input logic [7:0] b0,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2);
    mouse_pkt_t p;
    p.dx  = {b0[XSIGN], b1};
    p.dy  = {b0[YSIGN], b2};
    p.btn = {b0[BTN_M], b0[BTN_R], b0[BTN_L]};
    p.ovf = {b0[YOVF], b0[XOVF]};
    return p;
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: pin synchronizers, falling-edge detect,
// 11-bit frame FSM and inter-edge timeout. Optional clock glitch filter is
// enabled with PS2_RX_GLITCH_FILTER_EN.
module ps2_rx_byte
  import ps2_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  if (FILTER_LEN < 2) begin : g_filter_len_chk
    $error("FILTER_LEN must be at least 2");
  end

  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic w_fall, w_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

`ifdef PS2_RX_GLITCH_FILTER_EN
  logic [FILTER_LEN-1:0] r_filt_sh, r_dat_dl;
  logic                  r_clk_filt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt_sh  <= '1;
      r_dat_dl   <= '1;
      r_clk_filt <= 1'b1;
    end else begin
      r_filt_sh <= {r_filt_sh[FILTER_LEN-2:0], r_clk_s2};
      r_dat_dl  <= {r_dat_dl[FILTER_LEN-2:0], r_dat_s2};
      if (&r_filt_sh)       r_clk_filt <= 1'b1;
      else if (~|r_filt_sh) r_clk_filt <= 1'b0;
    end
  end

  // Edge fires in the cycle the window first reads all-low, before the
  // filtered level itself flips, so it is a single-cycle pulse.
  assign w_fall = r_clk_filt & ~|r_filt_sh;
  assign w_dat  = r_dat_dl[FILTER_LEN-1];
`else
  logic r_clk_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_clk_prev <= 1'b1;
    else          r_clk_prev <= r_clk_s2;
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_dat  = r_dat_s2;
`endif

  rx_state_e       r_state, w_state_nxt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [TW-1:0]   r_to_cnt;
  logic            w_timeout, w_frame_ok;

  assign w_timeout  = (r_state != IDLE) && (r_to_cnt == TO_MAX);
  assign w_frame_ok = w_dat && (^{r_shift, r_par});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_en || w_timeout) begin
      w_state_nxt = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    if (!w_dat) w_state_nxt = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        PARITY:  w_state_nxt = STOP;
        STOP:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_byte_valid = 1'b0;
    o_frame_err  = 1'b0;
    if (i_en) begin
      if (w_timeout) begin
        o_frame_err = 1'b1;
      end else if (w_fall && r_state == STOP) begin
        o_byte_valid = w_frame_ok;
        o_frame_err  = ~w_frame_ok;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (!i_en || r_state == IDLE || w_fall) r_to_cnt <= '0;
      else                                     r_to_cnt <= r_to_cnt + 1'b1;
      if (i_en && w_fall) begin
        case (r_state)
          IDLE:   r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: r_par <= w_dat;
          default: ;
        endcase
      end
    end
  end

  assign o_byte = r_shift;

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse stream-mode packet receiver: assembles 3-byte packets from the
// byte receiver into signed deltas, buttons and overflow flags.
// Optional clock glitch filter: define PS2_RX_GLITCH_FILTER_EN.
module ps2_mouse_packet_rx
  import ps2_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       pkt_valid,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       button_left,
  output logic       button_right,
  output logic       button_middle,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       frame_err
);

  logic       w_byte_valid, w_frame_err;
  logic [7:0] w_byte;

  ps2_rx_byte #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) u_byte (
    .i_clk        (CLOCK_50),
    .i_rst_n      (reset_n),
    .i_en         (rx_en),
    .i_ps2_clk    (ps2_clk_in),
    .i_ps2_dat    (ps2_dat_in),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (w_frame_err)
  );

  logic [1:0] r_idx;
  logic [7:0] r_b0, r_b1;
  mouse_pkt_t r_pkt;
  logic       r_pkt_valid, r_frame_err;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_pkt       <= '0;
      r_pkt_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      r_frame_err <= w_frame_err;
      if (!rx_en || w_frame_err) begin
        r_idx <= '0;
      end else if (w_byte_valid) begin
        case (r_idx)
          2'd0: if (w_byte[SYNC]) begin  // resync: only a sync-marked byte can lead
            r_b0  <= w_byte;
            r_idx <= 2'd1;
          end
          2'd1: begin
            r_b1  <= w_byte;
            r_idx <= 2'd2;
          end
          default: begin
            r_pkt       <= build_pkt(r_b0, r_b1, w_byte);
            r_pkt_valid <= 1'b1;
            r_idx       <= 2'd0;
          end
        endcase
      end
    end
  end

  assign pkt_valid     = r_pkt_valid;
  assign frame_err     = r_frame_err;
  assign dx            = r_pkt.dx;
  assign dy            = r_pkt.dy;
  assign button_left   = r_pkt.btn[0];
  assign button_right  = r_pkt.btn[1];
  assign button_middle = r_pkt.btn[2];
  assign x_ovf         = r_pkt.ovf[0];
  assign y_ovf         = r_pkt.ovf[1];

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Scoreboard bench for ps2_mouse_packet_rx: drives PS/2 frames bit by bit,
// queues expected packets/errors and checks them as the DUT strobes.
module tb_ps2_mouse_packet_rx;

  localparam int TO   = 1000;
  localparam int HALF = 100;   // PS/2 half period in system clocks

  logic       CLOCK_50 = 1'b0;
  logic       reset_n, rx_en, ps2_clk_in, ps2_dat_in;
  logic       pkt_valid, frame_err;
  logic [8:0] dx, dy;
  logic       button_left, button_right, button_middle, x_ovf, y_ovf;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_mouse_packet_rx #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(4)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .rx_en         (rx_en),
    .ps2_clk_in    (ps2_clk_in),
    .ps2_dat_in    (ps2_dat_in),
    .pkt_valid     (pkt_valid),
    .dx            (dx),
    .dy            (dy),
    .button_left   (button_left),
    .button_right  (button_right),
    .button_middle (button_middle),
    .x_ovf         (x_ovf),
    .y_ovf         (y_ovf),
    .frame_err     (frame_err)
  );

  typedef struct {
    logic [8:0] dx;
    logic [8:0] dy;
    logic [2:0] btn;  // {m, r, l}
    logic [1:0] ovf;  // {y, x}
  } exp_t;

  exp_t pkt_q[$];
  int   err_exp = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_pv = 1'b0, prev_fe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input logic [8:0] x, input logic [8:0] y,
                      input logic [2:0] b, input logic [1:0] o);
    exp_t e;
    e.dx = x; e.dy = y; e.btn = b; e.ovf = o;
    pkt_q.push_back(e);
  endtask

  // Data changes mid-high; clock falls half a high phase later.
  task automatic send_bit(input logic b);
    ps2_dat_in = b;
    cyc(HALF / 2);
    ps2_clk_in = 1'b0;
    cyc(HALF);
    ps2_clk_in = 1'b1;
    cyc(HALF / 2);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d) ^ bad_par);
    send_bit(1'b1);
    cyc(3 * HALF);
  endtask

  always @(negedge CLOCK_50) begin
    if (pkt_valid) begin
      chk("pv_width", {31'd0, prev_pv}, 0);
      chk("pkt_expected", {31'd0, pkt_q.size() > 0}, 1);
      if (pkt_q.size() > 0) begin
        exp_t e;
        e = pkt_q.pop_front();
        chk("dx", {23'd0, dx}, {23'd0, e.dx});
        chk("dy", {23'd0, dy}, {23'd0, e.dy});
        chk("btn", {29'd0, button_middle, button_right, button_left}, {29'd0, e.btn});
        chk("ovf", {30'd0, y_ovf, x_ovf}, {30'd0, e.ovf});
      end
    end
    if (frame_err) begin
      chk("fe_width", {31'd0, prev_fe}, 0);
      chk("err_expected", {31'd0, err_exp > 0}, 1);
      if (err_exp > 0) err_exp--;
    end
    prev_pv = pkt_valid;
    prev_fe = frame_err;
  end

  task automatic chk_outs_zero(input string tag);
    chk(tag, {dx, dy, button_left, button_right, button_middle, x_ovf, y_ovf,
              pkt_valid, frame_err}, 0);
  endtask

  task automatic drained(input string tag);
    cyc(20);
    chk(tag, pkt_q.size() + err_exp, 0);
  endtask

  initial begin
    reset_n = 1'b0; rx_en = 1'b1; ps2_clk_in = 1'b1; ps2_dat_in = 1'b1;
    cyc(5);
    chk_outs_zero("reset_outs");
    reset_n = 1'b1;
    cyc(10);
    chk_outs_zero("idle_outs");

    push(9'h005, 9'h003, 3'b001, 2'b00);
    send_byte(8'h09); send_byte(8'h05); send_byte(8'h03);
    drained("pkt_pos");

    push(9'h1FB, 9'h1F6, 3'b010, 2'b00);
    send_byte(8'h3A); send_byte(8'hFB); send_byte(8'hF6);
    drained("pkt_neg");

    err_exp++;
    send_byte(8'h08, 1'b1);
    drained("parity_err");
    push(9'h001, 9'h002, 3'b000, 2'b00);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    drained("pkt_after_err");

    push(9'h007, 9'h000, 3'b000, 2'b00);
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h07); send_byte(8'h00);
    drained("sync_discard");

    // Start + 4 data bits then silence, with clock idle high.
    err_exp++;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(TO + 200);
    drained("timeout_err");
    push(9'h001, 9'h001, 3'b001, 2'b00);
    send_byte(8'h09); send_byte(8'h01); send_byte(8'h01);
    drained("pkt_after_to");

    // Reset after two bytes; leftover 0x02 lacks sync so it is dropped.
    send_byte(8'h09); send_byte(8'h04);
    reset_n = 1'b0;
    cyc(3);
    chk_outs_zero("midreset_outs");
    reset_n = 1'b1;
    cyc(5);
    push(9'h002, 9'h002, 3'b100, 2'b00);
    send_byte(8'h02);
    send_byte(8'h0C); send_byte(8'h02); send_byte(8'h02);
    drained("pkt_after_reset");

    // Lead byte, then rx_en dropped mid-frame of an all-ones byte and raised
    // again before its tail: packet index must restart.
    send_byte(8'h09);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_en = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rx_en = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    cyc(3 * HALF);
    push(9'h006, 9'h001, 3'b001, 2'b00);
    send_byte(8'h09); send_byte(8'h06); send_byte(8'h01);
    drained("pkt_after_en");

    chk("pkt_q_empty", pkt_q.size(), 0);
    chk("err_exp_zero", err_exp, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_rx.md
Name: ps2_mouse_packet_rx

Overview:
- Receive-only PS/2 front end that deserializes device-to-host frames from the mouse and assembles 3-byte stream-mode packets.
- Sits directly upstream of the mouse position/binning stage.
- Outputs signed 9-bit X/Y deltas, button states and overflow flags, with a one-cycle packet strobe.
- Line drive (host-to-device commands) is out of scope; PS2_CLK/PS2_DAT are observed as inputs only.

Parameters:
- TIMEOUT_CYCLES, 100000, CLOCK_50 cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms).
- FILTER_LEN, 4, samples that must agree before the filtered PS/2 clock changes (used only with the optional feature).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- rx_en  in  1  receive enable; low forces idle and drops any partial packet
- ps2_clk_in  in  1  raw PS2_CLK pin level
- ps2_dat_in  in  1  raw PS2_DAT pin level
- pkt_valid  out  1  one-cycle strobe, new packet on the outputs
- dx  out  9  signed X delta, {b0[4], b1}
- dy  out  9  signed Y delta, {b0[5], b2}
- button_left / button_right / button_middle  out  1 each  b0[0] / b0[1] / b0[2]
- x_ovf / y_ovf  out  1 each  b0[6] / b0[7]
- frame_err  out  1  one-cycle strobe on parity, stop or timeout error

Behaviour:
- Reset (async assert, sync deassert inside CLOCK_50 domain):
  - All outputs 0.
  - Synchronizer flops 1.
  - FSM IDLE, byte index 0, timeout counter 0.
- Input path: two-flop synchronizer on each pin. Falling edge = prev synced clk 1 and current 0. Data is sampled in that same cycle.
- Frame FSM, advancing only on falling edges:
  - IDLE: dat=0 -> DATA, bit count 0; dat=1 -> ignored.
  - DATA: shift dat in LSB-first; after the 8th bit -> PARITY.
  - PARITY: latch bit -> STOP.
  - STOP: if dat=1 and (XOR of data and parity)=1 (odd parity), emit byte_valid; else pulse frame_err. Either way -> IDLE.
- Timeout:
  - Counter clears on every falling edge and while in IDLE.
  - Reaching TIMEOUT_CYCLES-1 outside IDLE -> IDLE, byte index 0, frame_err pulse.
- Packet assembly on byte_valid:
  - Index 0: accept only if bit3=1 (sync bit); otherwise discard and stay at index 0.
  - Index 1: store the byte as X.
  - Index 2: store the byte as Y; update all outputs; pulse pkt_valid; index -> 0.
- Latency: the stop-bit edge is detected at cycle N; outputs update and pkt_valid=1 at cycle N+1.
- Outputs hold their values between packets. pkt_valid and frame_err are never high for more than 1 cycle.
- Any frame_err sets byte index to 0, so the partial packet is dropped.
- rx_en=0: FSM IDLE, index 0, no strobes; synchronizers keep running. Re-enable mid-frame: bits until the next start bit (dat=0 in IDLE) are ignored.
- reset_n asserted mid-frame: immediate return to the reset state; no strobe is emitted.

Optional Feature:
- Macro: PS2_RX_GLITCH_FILTER_EN.
- Defined: the synced clock feeds a FILTER_LEN shift register. The filtered clock changes only when all FILTER_LEN samples equal the new level. Edge detection uses the filtered clock; data is sampled from a data line delayed to match. Edge latency grows by FILTER_LEN cycles; pulses shorter than FILTER_LEN cycles are rejected.
- Undefined: edge detection uses the synced clock directly; FILTER_LEN is unused.

Decomposition:
- Package ps2_rx_pkg:
  - Frame FSM state enum (IDLE, DATA, PARITY, STOP).
  - Byte-0 bit index constants: BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7.
  - Packed struct mouse_pkt_t holding dx, dy, buttons and ovf.
- Sub-module ps2_rx_byte: synchronizer, optional filter, edge detect, frame FSM and timeout. Outputs byte_valid, byte and frame_err.
- Top level: packet index and output registers.

Test Plan:
- Bench PS/2 clock period 80 us (4000 cycles); data changes mid-high phase.
- Bytes 0x09, 0x05, 0x03 -> one pkt_valid; dx=+5, dy=+3, left=1, right=0, middle=0, ovf=0.
- Bytes 0x3A, 0xFB, 0xF6 -> dx=0x1FB (-5), dy=0x1F6 (-10), right=1, left=0.
- Byte 0x08 sent with wrong parity bit -> frame_err one cycle, no pkt_valid. Then 0x08, 0x01, 0x02 -> dx=1, dy=2.
- Lead byte 0x00 (sync bit clear), then 0x08, 0x07, 0x00 -> 0x00 is discarded; pkt_valid with dx=7, dy=0.
- Start + 4 bits, then idle 100000 cycles -> frame_err. Then a full packet 0x09, 0x01, 0x01 is received correctly.
- reset_n pulsed low after the 2nd byte of a packet -> outputs 0. The remaining byte plus a new packet 0x0C, 0x02, 0x02 yields exactly one pkt_valid, with middle=1, dx=2, dy=2.
